// File: rtl/regfile_req_encoder42.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_req_encoder42
//  Description : Sequential 4:2 request encoder for register-file slots.
//                Captures one of four request lines and presents its index
//                on a registered valid/ready output. Returns a one-cycle
//                one-hot acknowledge to the granted slot. The enable input
//                is active-low.
//                Selection is round-robin by default. A build option
//                (REGFILE_ENC_FIXED_PRIO_EN) gives fixed priority with
//                slot 3 highest and no round-robin pointer register.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_req_encoder42 #(
    parameter int unsigned NREQ      = 4,
    parameter logic [1:0]  RESET_PTR = 2'd3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en_n,
    input  logic [NREQ-1:0] req,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [1:0]      idx,
    output logic            multi,
    output logic [NREQ-1:0] ack
);

    logic            valid_q, valid_d;
    logic [1:0]      idx_q,   idx_d;
    logic            multi_q, multi_d;
    logic [NREQ-1:0] ack_q,   ack_d;

    logic [1:0]      w_sel;
    logic            w_capture;
    logic            w_accept;

`ifdef REGFILE_ENC_FIXED_PRIO_EN
    // Fixed priority pick: highest-numbered requesting slot wins.
    always_comb begin
        w_sel = 2'd0;
        if (req[3])      w_sel = 2'd3;
        else if (req[2]) w_sel = 2'd2;
        else if (req[1]) w_sel = 2'd1;
        else             w_sel = 2'd0;
    end
`else
    logic [1:0] ptr_q, ptr_d;

    // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr (wrapping mod 4).
    always_comb begin
        logic       found;
        logic [1:0] cand;
        w_sel = ptr_q;
        found = 1'b0;
        cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + k[1:0];
            if (!found && req[cand]) begin
                w_sel = cand;
                found = 1'b1;
            end
        end
    end

    // Pointer follows the last granted slot so it is searched last next time.
    always_comb begin
        ptr_d = ptr_q;
        if (w_capture) ptr_d = w_sel;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ptr_q <= RESET_PTR;
        else         ptr_q <= ptr_d;
    end
`endif

    // A new selection is taken only when enabled, the output slot is free or
    // draining this cycle, and someone is actually requesting.
    assign w_accept  = valid_q && out_ready;
    assign w_capture = !en_n && (!valid_q || out_ready) && (req != '0);

    // Next-state for the output holding register and the ack pulse.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        multi_d = multi_q;
        ack_d   = '0;
        if (w_capture) begin
            valid_d      = 1'b1;
            idx_d        = w_sel;
            multi_d      = (req & (req - 1'b1)) != '0;
            ack_d[w_sel] = 1'b1;
        end else if (w_accept) begin
            valid_d = 1'b0;
        end
    end

    // Output registers; reset discards any pending selection immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            idx_q   <= 2'd0;
            multi_q <= 1'b0;
            ack_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            multi_q <= multi_d;
            ack_q   <= ack_d;
        end
    end

    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign multi     = multi_q;
    assign ack       = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_req_encoder42.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_req_encoder42
//  Description : Scoreboard bench for regfile_req_encoder42. A behavioural
//                model predicts the registered outputs for every cycle; the
//                prediction is queued when inputs are driven and compared
//                after the following rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_req_encoder42;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en_n;
    logic [3:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] idx;
    logic       multi;
    logic [3:0] ack;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] idx;
        logic       m;
        logic [3:0] ack;
    } exp_t;

    exp_t sb_q[$];

    // Model state
    logic       m_valid;
    logic [1:0] m_idx;
    logic       m_multi;
    logic [3:0] m_ack;
    logic [1:0] m_ptr;

    regfile_req_encoder42 #(.NREQ(4), .RESET_PTR(2'd3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en_n      (en_n),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .idx       (idx),
        .multi     (multi),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_sel(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] res;
        res = 2'd0;
`ifdef REGFILE_ENC_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            if (r[i]) res = 2'(i);
`else
        for (int k = 3; k >= 0; k--) begin
            int s;
            s = (int'(p) + 1 + k) % 4;
            if (r[s]) res = 2'(s);
        end
`endif
        return res;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 2'd0;
        m_multi = 1'b0;
        m_ack   = 4'd0;
        m_ptr   = 2'd3;
    endtask

    // Predict the next cycle from current inputs, queue it, clock, compare.
    task automatic step();
        exp_t       e;
        logic [1:0] s;
        logic       cap;
        s   = model_sel(req, m_ptr);
        cap = !en_n && (!m_valid || out_ready) && (req != 4'd0);
        m_ack = 4'd0;
        if (cap) begin
            m_valid  = 1'b1;
            m_idx    = s;
            m_multi  = ($countones(req) > 1);
            m_ack[s] = 1'b1;
            m_ptr    = s;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        sb_q.push_back('{v: m_valid, idx: m_idx, m: m_multi, ack: m_ack});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("out_valid", {31'd0, out_valid}, {31'd0, e.v});
            check("idx",       {30'd0, idx},       {30'd0, e.idx});
            check("multi",     {31'd0, multi},     {31'd0, e.m});
            check("ack",       {28'd0, ack},       {28'd0, e.ack});
        end
    endtask

    // Reset held across one rising edge; released 1 time unit after it.
    task automatic do_reset();
        resetn = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        en_n      = 1'b1;
        req       = 4'd0;
        out_ready = 1'b0;
        model_reset();
        #2;
        do_reset();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ack",   {28'd0, ack},       32'd0);

        // Single request, then idle.
        en_n = 1'b0; out_ready = 1'b1; req = 4'b0100;
        step();
        check("single_idx", {30'd0, idx}, 32'd2);
        req = 4'b0000;
        step();
        check("single_drain", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while holding idx=2.
        req = 4'b0100; out_ready = 1'b0;
        step();
        step();
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_idx",   {30'd0, idx},       32'd0);
        check("arst_multi", {31'd0, multi},     32'd0);
        check("arst_ack",   {28'd0, ack},       32'd0);
        do_reset();

        // All four requesting: rotation from reset pointer.
        req = 4'b1111; out_ready = 1'b1; en_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
`ifndef REGFILE_ENC_FIXED_PRIO_EN
            check("rr_seq", {30'd0, idx}, 32'(k % 4));
`endif
            check("rr_multi", {31'd0, multi}, 32'd1);
        end

        // Stall while a new request waits, then release.
        do_reset();
        req = 4'b0010; out_ready = 1'b1;
        step();
        req = 4'b1000; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_idx", {30'd0, idx}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        check("stall_rel_ack", {28'd0, ack}, 32'h8);
        req = 4'b0000;
        step();

        // Disabled: nothing captured, then enable.
        do_reset();
        en_n = 1'b1; req = 4'b0011; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        en_n = 1'b0;
        step();
`ifdef REGFILE_ENC_FIXED_PRIO_EN
        check("en_idx", {30'd0, idx}, 32'd1);
`else
        check("en_idx", {30'd0, idx}, 32'd0);
`endif
        check("en_multi", {31'd0, multi}, 32'd1);

        // Held mixed request, then drop the top slot.
        do_reset();
        req = 4'b1011; out_ready = 1'b1; en_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef REGFILE_ENC_FIXED_PRIO_EN
            check("fp_idx3", {30'd0, idx}, 32'd3);
`endif
        end
        req = 4'b0011;
        step();
`ifdef REGFILE_ENC_FIXED_PRIO_EN
        check("fp_idx1", {30'd0, idx}, 32'd1);
`endif

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            req       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            en_n      = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_req_encoder42.md
Name: regfile_req_encoder42

Overview:
- Sequential 4:2 encoder: the inverse of the register-file 2:4 write-select decoder.
- Collects four one-hot-style request lines from register-file slots, selects one, and presents its 2-bit index on a registered valid/ready output to the downstream consumer (read-port mux / control FSM).
- Returns a one-cycle acknowledge pulse to the granted slot so it can drop its request.
- Enable is active-low, matching the decoder's enable polarity.

Parameters:
- NREQ, 4, number of request lines; fixed at 4 (index width 2). Any other value is unsupported.
- RESET_PTR, 3, reset value of round-robin pointer, so the first search starts at slot 0.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- en_n  input  1  active-low enable; 1 blocks new captures
- req  input  4  request lines, req[i] = slot i wants service
- out_ready  input  1  consumer accepts idx this cycle
- out_valid  output  1  idx/multi hold a valid selection
- idx  output  2  encoded slot number (y3→3 … y0→0 ordering)
- multi  output  1  more than one req bit was set at capture
- ack  output  4  one-hot, one-cycle pulse to granted slot

Behaviour:
- Reset (resetn=0, asynchronous, immediate): out_valid=0, idx=2'b00, multi=0, ack=4'b0000, ptr=RESET_PTR. Any pending selection is discarded; nothing is replayed after reset.
- Capture condition: en_n=0 AND (out_valid=0 OR out_ready=1) AND req≠0.
- On a capture at edge k:
  - idx = selected slot; out_valid=1; multi = (popcount(req)>1).
  - ack = one-hot(selected) for exactly the cycle after edge k.
  - ptr = selected.
- Latency: req asserted before edge k gives out_valid and ack visible after edge k (1 cycle).
- Accept, no new capture: out_valid=1, out_ready=1, and (req=0 or en_n=1). Next edge: out_valid=0; idx and multi hold their last values.
- Stall: out_valid=1, out_ready=0. idx, multi, and out_valid hold; ack=0; req ignored; ptr unchanged.
- Back-to-back: accept and capture may occur on the same edge. out_valid stays 1, idx updates, and there is no bubble.
- en_n=1: a held selection still drains normally; no capture occurs; ack=0.
- ack is never asserted in a cycle without a capture. ack is never multi-hot.
- A requester must hold req until it sees ack. If req is still high after ack, that slot re-enters arbitration.
- Selection, default (round-robin): search slots ptr+1, ptr+2, ptr+3, ptr (mod 4) and take the first set bit. Wrap from 3 to 0 is required.
- req=0 under capture conditions: out_valid clears if accepted; idx, ptr, and multi are unchanged.
- All outputs are registered; there is no combinational path from req or out_ready to any output.

Optional Feature:
- Macro: REGFILE_ENC_FIXED_PRIO_EN.
- Defined: fixed priority 3>2>1>0, matching the decoder's y3-first ordering. ptr is not implemented, and RESET_PTR is ignored.
- Undefined: round-robin as above.
- All other behaviour (handshake, multi, ack) is identical in both modes.

Test Plan:
- Reset: drive resetn=0 mid-cycle while out_valid=1 and idx=2 -> out_valid=0, idx=0, ack=0 immediately, without waiting for a clock edge.
- Single request, out_ready=1: req=4'b0100 at edge 1 -> after edge 1, idx=2, out_valid=1, multi=0, ack=4'b0100 for one cycle; after edge 2 with req=0, out_valid=0.
- Round-robin fairness: req=4'b1111 held, out_ready=1, first capture after reset -> idx sequence 0,1,2,3,0 on consecutive cycles, multi=1 each cycle, no bubbles.
- Stall: capture idx=1, then out_ready=0 for 3 cycles while req=4'b1000 -> idx=1 and out_valid=1 held, ack=0; release out_ready -> next cycle idx=3, ack=4'b1000.
- Enable: en_n=1 with req=4'b0011 -> out_valid stays 0, ack=0 for 5 cycles; drop en_n to 0 -> one cycle later idx=0 (ptr=3 after reset), multi=1.
- Fixed-priority build (REGFILE_ENC_FIXED_PRIO_EN): req=4'b1011 held, out_ready=1 -> idx=3 every cycle; drop req[3] -> idx=1.
